// File: rtl/ks_sum_stage_if.sv
// rtl/ks_sum_stage_if.sv - handshake and data bundle between prefix network, sum stage and consumer
interface ks_sum_stage_if;
   logic        i_valid;
   logic        o_ready;
   logic        i_c0;
   logic [15:0] i_p_save;
   logic [15:0] i_gk;
   logic        o_valid;
   logic        i_ready;
   logic [15:0] o_sum;
   logic        o_cout;
   logic        o_ovf;
   logic        o_zero;
   logic        o_neg;

   modport master (
      output i_valid, i_c0, i_p_save, i_gk, i_ready,
      input  o_ready, o_valid, o_sum, o_cout, o_ovf, o_zero, o_neg
   );

   modport slave (
      input  i_valid, i_c0, i_p_save, i_gk, i_ready,
      output o_ready, o_valid, o_sum, o_cout, o_ovf, o_zero, o_neg
   );
endinterface

// File: rtl/ks_sum_stage.sv
// rtl/ks_sum_stage.sv - Kogge-Stone final sum stage with flags and DEPTH-entry output FIFO; KS_SUM_SAT_EN enables saturation
module ks_sum_stage #(
   parameter int DEPTH = 2
) (
   input logic           i_clk,
   input logic           i_rst,
   ks_sum_stage_if.slave bus
);

   localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
   localparam int CW = $clog2(DEPTH) + 1;
   localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);
   localparam logic [PW-1:0] LAST_C  = PW'(DEPTH - 1);

   // entry layout: {sum[15:0], cout, ovf, zero, neg}
   logic [19:0]   mem [DEPTH];
   logic [PW-1:0] wr_ptr;
   logic [PW-1:0] rd_ptr;
   logic [CW-1:0] count;
   logic          ready_q;

   logic [15:0]   sum_raw;
   logic [15:0]   sum_fin;
   logic          cout_c;
   logic          ovf_c;
   logic [19:0]   entry_in;
   logic [19:0]   head;
   logic          push;
   logic          pop;
   logic [CW-1:0] count_next;

   // sum bits from saved propagate and the carry into each bit, plus flags on the final value
   always_comb begin
      sum_raw      = '0;
      sum_raw[0]   = bus.i_p_save[0] ^ bus.i_c0;
      sum_raw[15:1] = bus.i_p_save[15:1] ^ bus.i_gk[14:0];
      cout_c       = bus.i_gk[15];
      ovf_c        = bus.i_gk[15] ^ bus.i_gk[14];
      sum_fin      = sum_raw;
`ifdef KS_SUM_SAT_EN
      if (ovf_c) begin
         sum_fin = bus.i_gk[15] ? 16'h8000 : 16'h7FFF;
      end
`endif
      entry_in = {sum_fin, cout_c, ovf_c, (sum_fin == 16'h0000), sum_fin[15]};
   end

   // handshake decode and next occupancy; ready_q guarantees no push while full
   always_comb begin
      push       = bus.i_valid & ready_q;
      pop        = (count != '0) & bus.i_ready;
      count_next = count;
      case ({push, pop})
         2'b10:   count_next = count + CW'(1);
         2'b01:   count_next = count - CW'(1);
         default: count_next = count;
      endcase
   end

   // FIFO storage, pointers, occupancy and registered ready; reset discards everything
   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         wr_ptr  <= '0;
         rd_ptr  <= '0;
         count   <= '0;
         ready_q <= 1'b0;
         for (int i = 0; i < DEPTH; i++) begin
            mem[i] <= '0;
         end
      end else begin
         if (push) begin
            mem[wr_ptr] <= entry_in;
            wr_ptr      <= (wr_ptr == LAST_C) ? '0 : wr_ptr + PW'(1);
         end
         if (pop) begin
            rd_ptr <= (rd_ptr == LAST_C) ? '0 : rd_ptr + PW'(1);
         end
         count   <= count_next;
         ready_q <= (count_next < DEPTH_C);
      end
   end

   // outputs always reflect the head entry, so they hold steady under backpressure
   always_comb begin
      head        = mem[rd_ptr];
      bus.o_sum   = head[19:4];
      bus.o_cout  = head[3];
      bus.o_ovf   = head[2];
      bus.o_zero  = head[1];
      bus.o_neg   = head[0];
      bus.o_valid = (count != '0);
      bus.o_ready = ready_q;
   end

endmodule

// File: tb/tb_ks_sum_stage.sv
// tb/tb_ks_sum_stage.sv - self-checking bench for ks_sum_stage
module tb_ks_sum_stage;

   logic clk = 1'b0;
   logic rst = 1'b1;
   always #5 clk = ~clk;

   ks_sum_stage_if bus ();

   ks_sum_stage #(.DEPTH(2)) dut (
      .i_clk (clk),
      .i_rst (rst),
      .bus   (bus.slave)
   );

   typedef struct {
      logic [15:0] a;
      logic [15:0] b;
      logic        c0;
      logic [15:0] sum;
      logic        cout;
      logic        ovf;
      logic        zero;
      logic        neg;
   } vec_t;

   int checks = 0;
   int errors = 0;
   int n_out  = 0;
   logic [19:0] sb[$];
   vec_t tbl[7];

   // carry out of every bit position, as the prefix network would deliver it
   function automatic logic [15:0] gk_of(input logic [15:0] a, input logic [15:0] b, input logic c0);
      logic c;
      logic [15:0] g;
      c = c0;
      for (int k = 0; k < 16; k++) begin
         c = (a[k] & b[k]) | ((a[k] ^ b[k]) & c);
         g[k] = c;
      end
      return g;
   endfunction

   // arithmetic reference for the result record
   function automatic logic [19:0] exp_of(input logic [15:0] a, input logic [15:0] b, input logic c0);
      logic [16:0] t;
      logic [15:0] s;
      logic cout, ovf;
      t = {1'b0, a} + {1'b0, b} + {16'b0, c0};
      s = t[15:0];
      cout = t[16];
      ovf = (a[15] == b[15]) && (s[15] != a[15]);
`ifdef KS_SUM_SAT_EN
      if (ovf) s = a[15] ? 16'h8000 : 16'h7FFF;
`endif
      return {s, cout, ovf, (s == 16'h0000), s[15]};
   endfunction

   task automatic check(input string name, input logic [19:0] got, input logic [19:0] want);
      checks++;
      if (got !== want) begin
         errors++;
         $display("FAIL %s got %h want %h", name, got, want);
      end
   endtask

   task automatic drive(input logic [15:0] a, input logic [15:0] b, input logic c0);
      bus.i_p_save = a ^ b;
      bus.i_gk = gk_of(a, b, c0);
      bus.i_c0 = c0;
   endtask

   // offer one result; called and returns at posedge+1
   task automatic send(input logic [15:0] a, input logic [15:0] b, input logic c0,
                       input logic [19:0] want, input bit release_ready);
      bit ok;
      ok = 0;
      drive(a, b, c0);
      bus.i_valid = 1'b1;
      for (int t = 0; t < 50; t++) begin
         @(negedge clk);
         if (bus.o_ready) begin
            ok = 1;
            break;
         end
         @(posedge clk);
         #1;
         if (release_ready) bus.i_ready = 1'b1;
      end
      if (!ok) begin
         checks++;
         errors++;
         $display("FAIL send_timeout got o_ready=0 want 1");
      end else begin
         sb.push_back(want);
      end
      @(posedge clk);
      #1;
      bus.i_valid = 1'b0;
   endtask

   task automatic mon();
      logic [19:0] e;
      forever begin
         @(negedge clk);
         if (!rst && bus.o_valid && bus.i_ready) begin
            n_out++;
            if (sb.size() == 0) begin
               checks++;
               errors++;
               $display("FAIL out_unexpected got sum=%h want none", bus.o_sum);
            end else begin
               e = sb.pop_front();
               check("out_data", {bus.o_sum, bus.o_cout, bus.o_ovf, bus.o_zero, bus.o_neg}, e);
            end
         end
      end
   endtask

   // wait for the scoreboard to empty, then confirm the FIFO went idle; returns at posedge+1
   task automatic wait_drain(input string name);
      for (int t = 0; t < 40; t++) begin
         if (sb.size() == 0) break;
         @(negedge clk);
      end
      check({name, "_sb_empty"}, 20'(sb.size()), 20'd0);
      @(negedge clk);
      check({name, "_idle_valid"}, 20'(bus.o_valid), 20'd0);
      @(posedge clk);
      #1;
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog got timeout want finish");
      $fatal(1);
   end

   initial begin
      logic [15:0] a, b;
      logic c0;
      logic [19:0] e1, e2, e3;
      int n0;

      tbl[0] = '{16'h1234, 16'h0001, 1'b0, 16'h1235, 1'b0, 1'b0, 1'b0, 1'b0};
      tbl[1] = '{16'hFFFF, 16'h0001, 1'b0, 16'h0000, 1'b1, 1'b0, 1'b1, 1'b0};
`ifdef KS_SUM_SAT_EN
      tbl[2] = '{16'h7FFF, 16'h0001, 1'b0, 16'h7FFF, 1'b0, 1'b1, 1'b0, 1'b0};
      tbl[3] = '{16'h8000, 16'h8000, 1'b0, 16'h8000, 1'b1, 1'b1, 1'b0, 1'b1};
      tbl[6] = '{16'h8000, 16'hFFFF, 1'b0, 16'h8000, 1'b1, 1'b1, 1'b0, 1'b1};
`else
      tbl[2] = '{16'h7FFF, 16'h0001, 1'b0, 16'h8000, 1'b0, 1'b1, 1'b0, 1'b1};
      tbl[3] = '{16'h8000, 16'h8000, 1'b0, 16'h0000, 1'b1, 1'b1, 1'b1, 1'b0};
      tbl[6] = '{16'h8000, 16'hFFFF, 1'b0, 16'h7FFF, 1'b1, 1'b1, 1'b0, 1'b0};
`endif
      tbl[4] = '{16'h0005, 16'h0003, 1'b1, 16'h0009, 1'b0, 1'b0, 1'b0, 1'b0};
      tbl[5] = '{16'hFFFF, 16'h0000, 1'b1, 16'h0000, 1'b1, 1'b0, 1'b1, 1'b0};

      bus.i_valid = 1'b0;
      bus.i_ready = 1'b0;
      drive(16'h0, 16'h0, 1'b0);
      fork
         mon();
      join_none

      // reset state
      repeat (2) @(posedge clk);
      @(negedge clk);
      check("rst_valid", 20'(bus.o_valid), 20'd0);
      check("rst_ready", 20'(bus.o_ready), 20'd0);
      check("rst_entry", {bus.o_sum, bus.o_cout, bus.o_ovf, bus.o_zero, bus.o_neg}, 20'd0);
      @(posedge clk);
      #1;
      rst = 1'b0;
      @(posedge clk);
      @(negedge clk);
      check("rst_release_ready", 20'(bus.o_ready), 20'd1);
      check("rst_release_valid", 20'(bus.o_valid), 20'd0);
      @(posedge clk);
      #1;

      // table vectors, consumer always ready
      bus.i_ready = 1'b1;
      for (int i = 0; i < 7; i++) begin
         send(tbl[i].a, tbl[i].b, tbl[i].c0,
              {tbl[i].sum, tbl[i].cout, tbl[i].ovf, tbl[i].zero, tbl[i].neg}, 1'b0);
      end
      wait_drain("table");

      // empty FIFO ignores i_ready
      for (int i = 0; i < 3; i++) begin
         @(negedge clk);
         check("empty_valid", 20'(bus.o_valid), 20'd0);
         check("empty_ready", 20'(bus.o_ready), 20'd1);
      end
      @(posedge clk);
      #1;

      // backpressure: two fill the FIFO, third waits upstream
      bus.i_ready = 1'b0;
      e1 = exp_of(16'h0100, 16'h0023, 1'b0);
      e2 = exp_of(16'h0FFF, 16'h0001, 1'b1);
      e3 = exp_of(16'hAAAA, 16'h5555, 1'b1);
      send(16'h0100, 16'h0023, 1'b0, e1, 1'b0);
      send(16'h0FFF, 16'h0001, 1'b1, e2, 1'b0);
      drive(16'hAAAA, 16'h5555, 1'b1);
      bus.i_valid = 1'b1;
      for (int i = 0; i < 3; i++) begin
         @(negedge clk);
         check("bp_ready", 20'(bus.o_ready), 20'd0);
         check("bp_valid", 20'(bus.o_valid), 20'd1);
         check("bp_head_hold", 20'(bus.o_sum), 20'(e1[19:4]));
         @(posedge clk);
         #1;
      end
      bus.i_ready = 1'b1;
      send(16'hAAAA, 16'h5555, 1'b1, e3, 1'b0);
      wait_drain("bp");

      // full throughput: one per cycle, occupancy stays at 1
      bus.i_ready = 1'b1;
      n0 = n_out;
      for (int i = 0; i < 8; i++) begin
         a = 16'($urandom);
         b = 16'($urandom);
         c0 = 1'($urandom);
         drive(a, b, c0);
         bus.i_valid = 1'b1;
         @(negedge clk);
         check("tp_ready", 20'(bus.o_ready), 20'd1);
         if (i > 0) check("tp_valid", 20'(bus.o_valid), 20'd1);
         sb.push_back(exp_of(a, b, c0));
         @(posedge clk);
         #1;
      end
      bus.i_valid = 1'b0;
      wait_drain("tp");
      check("tp_count", 20'(n_out - n0), 20'd8);

      // reset mid-stream with two buffered and one offered
      bus.i_ready = 1'b0;
      send(16'h1111, 16'h2222, 1'b0, exp_of(16'h1111, 16'h2222, 1'b0), 1'b0);
      send(16'h3333, 16'h4444, 1'b1, exp_of(16'h3333, 16'h4444, 1'b1), 1'b0);
      rst = 1'b1;
      drive(16'h5555, 16'h0001, 1'b0);
      bus.i_valid = 1'b1;
      @(posedge clk);
      @(negedge clk);
      check("midrst_valid", 20'(bus.o_valid), 20'd0);
      check("midrst_ready", 20'(bus.o_ready), 20'd0);
      sb.delete();
      @(posedge clk);
      #1;
      rst = 1'b0;
      bus.i_valid = 1'b0;
      bus.i_ready = 1'b1;
      @(posedge clk);
      @(negedge clk);
      check("midrst_release_ready", 20'(bus.o_ready), 20'd1);
      check("midrst_release_valid", 20'(bus.o_valid), 20'd0);
      check("midrst_cleared_sum", 20'(bus.o_sum), 20'd0);
      for (int i = 0; i < 3; i++) begin
         @(negedge clk);
         check("midrst_no_stale", 20'(bus.o_valid), 20'd0);
      end
      @(posedge clk);
      #1;

      // random vectors with random consumer stalls
      for (int i = 0; i < 30; i++) begin
         a = 16'($urandom);
         b = 16'($urandom);
         c0 = 1'($urandom);
         if (i % 5 == 0) a = 16'h7FF0 + 16'(i);
         bus.i_ready = 1'($urandom);
         send(a, b, c0, exp_of(a, b, c0), 1'b1);
      end
      bus.i_ready = 1'b1;
      wait_drain("rand");

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

// File: doc/ks_sum_stage.md
KS_SUM_STAGE -- requirements
Module: ks_sum_stage

Interface
REQ-001 SHALL have parameter DEPTH, default 2, output buffer entries; legal values 2, 4, 8 or 16.
REQ-002 SHALL have port i_clk, input, 1, sole clock; all state updates on the rising edge.
REQ-003 SHALL have port i_rst, input, 1, synchronous active-high reset.
REQ-004 SHALL have port i_valid, input, 1, upstream prefix-network result valid.
REQ-005 SHALL have port o_ready, output, 1, block can accept an upstream result.
REQ-006 SHALL have port i_c0, input, 1, carry-in forwarded by the prefix network.
REQ-007 SHALL have port i_p_save, input, 16, saved bitwise propagate p[k]=a[k]^b[k].
REQ-008 SHALL have port i_gk, input, 16, final group generate G[k:-1], the carry out of bit k.
REQ-009 SHALL have port o_valid, output, 1, buffer head holds a result.
REQ-010 SHALL have port i_ready, input, 1, downstream accepts the head.
REQ-011 SHALL have port o_sum, output, 16, result.
REQ-012 SHALL have port o_cout, o_ovf, o_zero, o_neg, each output, 1: carry-out, signed overflow, zero and negative flags.

Function
REQ-013 SHALL compute sum[0]=i_p_save[0]^i_c0 and sum[k]=i_p_save[k]^i_gk[k-1] for k=1..15.
REQ-014 SHALL compute cout=i_gk[15] and ovf=i_gk[15]^i_gk[14].
REQ-015 SHALL compute zero=(final o_sum==0) and neg=final o_sum[15], both after any saturation.
REQ-016 SHALL push the computed {sum,cout,ovf,zero,neg} into a DEPTH-entry FIFO on a cycle where i_valid and o_ready are both 1.
REQ-017 SHALL drive o_ready=1 exactly when the occupancy count is less than DEPTH, decoded from registered state only.
REQ-018 SHALL drive o_valid=1 exactly when the occupancy count is nonzero.
REQ-019 SHALL pop the head on a cycle where o_valid and i_ready are both 1.
REQ-020 SHALL have latency 1: a result pushed at edge N is visible on the outputs with o_valid=1 after edge N when the FIFO was empty.
REQ-021 SHALL, on a simultaneous push and pop, leave the count unchanged and advance both pointers.
REQ-022 SHALL, when full, ignore i_valid, drop no data and overwrite nothing.
REQ-023 SHALL, when empty, ignore i_ready without underflow.
REQ-024 SHALL wrap the read and write pointers modulo DEPTH.
REQ-025 SHALL drive data outputs from the entry at the read pointer at all times, stable while o_valid=1 and i_ready=0.
REQ-026 SHALL preserve order: results leave in acceptance order.

Reset
REQ-027 SHALL, while i_rst=1, clear the pointers, the count and all FIFO entries to 0.
REQ-028 SHALL, while i_rst=1, force o_valid=0 and o_ready=0; o_ready returns to 1 on the first cycle after i_rst deasserts.
REQ-029 SHALL drive o_sum=0 and o_cout, o_ovf, o_neg =0 and o_zero=0 (raw cleared entry) after reset.
REQ-030 SHALL, on reset asserted mid-stream, discard all buffered and in-flight results; no push occurs on a reset cycle.

Configuration
REQ-031 SHALL, with macro KS_SUM_SAT_EN defined, replace the sum with 16'h7FFF when ovf=1 and i_gk[15]=0 (positive overflow), and with 16'h8000 when ovf=1 and i_gk[15]=1; cout and ovf remain raw.
REQ-032 SHALL, without KS_SUM_SAT_EN, output the wrapped sum unmodified; the interface is identical in both builds.

Verification
REQ-033 SHALL cover basic add: a=16'h1234, b=16'h0001, c0=0 -> o_sum=16'h1235, cout=0, ovf=0, zero=0, neg=0, one cycle after acceptance.
REQ-034 SHALL cover carry and zero: a=16'hFFFF, b=16'h0001, c0=0 -> o_sum=16'h0000, cout=1, ovf=0, zero=1.
REQ-035 SHALL cover overflow: a=16'h7FFF, b=16'h0001 -> ovf=1, o_sum=16'h8000 and neg=1 without KS_SUM_SAT_EN; o_sum=16'h7FFF and neg=0 with it.
REQ-036 SHALL cover backpressure: i_ready=0 with DEPTH=2 and three results offered -> o_ready=0 after two pushes, third held upstream; results then drain in order when i_ready=1.
REQ-037 SHALL cover full throughput: continuous i_valid and i_ready=1 -> one result per cycle with the count constant at 1.
REQ-038 SHALL cover reset: assert i_rst with 2 entries buffered -> o_valid=0 the next cycle, o_ready=1 the cycle after release, and no stale result emitted.
